// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial two's complement adder/subtractor. An operand pair is captured
// on a start strobe, then one bit per clock is processed LSB first through a
// full-adder cell built from two half adders and a registered carry. After
// WIDTH cycles the parallel result and its carry/overflow flags are written.
//
// Ports:
//   clk   - clock, all logic on the rising edge
//   rst   - synchronous active-high reset, highest priority
//   start - request, only honoured in IDLE
//   sub   - 0 = a+b, 1 = a-b, captured with start
//   a, b  - operands, captured with start
//   busy  - high while bits are being processed
//   done  - one-cycle pulse when sum/cout/ovf update
//   sum   - registered result, held until the next completion
//   cout  - carry out of the MSB (for subtraction, 1 = no borrow)
//   ovf   - signed overflow, carry into MSB xor carry out of MSB
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] partial;
  logic [CW-1:0]    count;
  logic             carry;

  // Full adder built as two chained half adders on the current LSBs.
  logic halfSum;
  logic halfCarry;
  logic bitSum;
  logic bitCarry;
  logic cinMsb;

  always_comb begin
    halfSum   = opA[0] ^ opB[0];
    halfCarry = opA[0] & opB[0];
    bitSum    = halfSum ^ carry;
    bitCarry  = halfCarry | (halfSum & carry);
    // While the last bit is being processed, the live carry register holds
    // the carry into the MSB.
    cinMsb    = carry;
  end

  // Sequencer and datapath. Subtraction is a + ~b + 1, so the inverted b is
  // loaded and the carry is preset to 1. The partial result enters at the MSB
  // and shifts right, so after WIDTH bits it is already in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      opA     <= '0;
      opB     <= '0;
      partial <= '0;
      count   <= '0;
      carry   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opA     <= a;
            opB     <= sub ? ~b : b;
            carry   <= sub;
            count   <= '0;
            partial <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          partial <= {bitSum, partial[WIDTH-1:1]};
          opA     <= opA >> 1;
          opB     <= opB >> 1;
          carry   <= bitCarry;
          count   <= count + 1'b1;
          if (count == LAST) begin
            sum   <= {bitSum, partial[WIDTH-1:1]};
            cout  <= bitCarry;
            ovf   <= cinMsb ^ bitCarry;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status flags decode straight from the state register.
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
